parking_gate_sensor: RTL



---
 rtl/parking_pkg.sv | 72 +++++++
 rtl/beam_debounce.sv | 42 ++++
 rtl/parking_gate_sensor.sv | 84 ++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate sensor: FSM state set,
// beam polarity, default timing constants and the beam-driven transition rules.
package parking_pkg;

    localparam logic BEAM_BLOCKED = 1'b1;
    localparam int   DEF_DEBOUNCE_CYCLES = 4;
    localparam int   DEF_TIMEOUT_CYCLES  = 1000;

    typedef enum logic [3:0] {
        IDLE,
        EN_A,
        EN_AB,
        EN_B,
        EX_B,
        EX_BA,
        EX_A,
        AMBIG,
        FAULT
    } gate_state_t;

    // Beam-pattern transitions only; the timeout is layered on top by the caller.
    // Any pattern not listed for a state holds that state.
    function automatic gate_state_t beam_next_state(
        input gate_state_t state,
        input logic        fa,
        input logic        fb
    );
        logic        a;
        logic        b;
        gate_state_t nxt;
        a   = (fa == BEAM_BLOCKED);
        b   = (fb == BEAM_BLOCKED);
        nxt = state;
        case (state)
            IDLE: begin
                if (a && !b)      nxt = EN_A;
                else if (!a && b) nxt = EX_B;
                else if (a && b)  nxt = AMBIG;
            end
            EN_A: begin
                if (a && b)        nxt = EN_AB;
                else if (!a && !b) nxt = IDLE;
            end
            EN_AB: begin
                if (!a && b)      nxt = EN_B;
                else if (a && !b) nxt = EN_A;
            end
            EN_B: begin
                if (!a && !b)     nxt = IDLE;
                else if (a && b)  nxt = EN_AB;
            end
            EX_B: begin
                if (a && b)        nxt = EX_BA;
                else if (!a && !b) nxt = IDLE;
            end
            EX_BA: begin
                if (a && !b)      nxt = EX_A;
                else if (!a && b) nxt = EX_B;
            end
            EX_A: begin
                if (!a && !b)     nxt = IDLE;
                else if (a && b)  nxt = EX_BA;
            end
            AMBIG, FAULT: begin
                if (!a && !b) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/beam_debounce.sv
// Two-flop synchroniser followed by a debounce filter for one infrared beam.
// The filtered level only follows after DEBOUNCE_CYCLES consecutive disagreeing samples.
module beam_debounce
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic beam,
    output logic filtered
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] count;

    // The count never passes CNT_LAST, so it cannot wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            filtered <= 1'b0;
            count    <= '0;
        end else begin
            sync1 <= beam;
            sync2 <= sync1;
            if (sync2 == filtered) begin
                count <= '0;
            end else if (count >= CNT_LAST) begin
                filtered <= sync2;
                count    <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_gate_sensor.sv
// Decodes the two gate beams into single-cycle entry/exit pulses, drives the
// barrier request and flags stuck or ambiguous beam conditions.
module parking_gate_sensor
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic beamA,
    input  logic beamB,
    input  logic Full,
    output logic carIn,
    output logic carOut,
    output logic gateOpen,
    output logic fault
);

    localparam int               TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(TIMEOUT_CYCLES);

    logic             fa;
    logic             fb;
    gate_state_t      state;
    gate_state_t      beam_next;
    gate_state_t      state_next;
    logic             entry_ok;
    logic             entry_ok_next;
    logic             timed_out;
    logic [TMR_W-1:0] timer;

    beam_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk      (clk),
        .reset    (reset),
        .beam     (beamA),
        .filtered (fa)
    );

    beam_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk      (clk),
        .reset    (reset),
        .beam     (beamB),
        .filtered (fb)
    );

    // A genuine beam transition takes priority over a timeout landing on the same edge.
    assign beam_next     = beam_next_state(state, fa, fb);
    assign timed_out     = (beam_next == state) && (state != IDLE) && (state != FAULT)
                           && (timer >= TMR_LIMIT);
    assign state_next    = timed_out ? FAULT : beam_next;
    assign entry_ok_next = (state == IDLE && state_next == EN_A) ? !Full : entry_ok;

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            entry_ok <= 1'b0;
            timer    <= '0;
            carIn    <= 1'b0;
            carOut   <= 1'b0;
            gateOpen <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_next;
            entry_ok <= entry_ok_next;
            if (state_next != state) begin
                timer <= '0;
            end else if (timer != TMR_MAX) begin
                timer <= timer + 1'b1;
            end
            carIn  <= (state == EN_B) && (state_next == IDLE);
            carOut <= (state == EX_A) && (state_next == IDLE);
            fault  <= (state_next == FAULT);
            case (state_next)
                EN_A, EN_AB, EN_B: gateOpen <= entry_ok_next;
                EX_B, EX_BA, EX_A: gateOpen <= 1'b1;
                default:           gateOpen <= 1'b0;
            endcase
        end
    end

endmodule
